// File: rtl/uart_cpu_oci_trace_capture_if.sv
//------------------------------------------------------------------------------
// Module      : uart_cpu_oci_trace_capture_if
// Description : Trace-word write strobe and ready/valid drain port bundle for
//               the OCI trace capture block. The entry width grows by TS_W
//               when OCI_TRACE_TIMESTAMP_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_cpu_oci_trace_capture_if #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4,
    parameter int TS_W   = 16
);
`ifdef OCI_TRACE_TIMESTAMP_EN
    localparam int TS_EN = 1;
`else
    localparam int TS_EN = 0;
`endif
    localparam int RD_W = CNT_W + DATA_W + (TS_EN * TS_W);

    logic              dct_valid;
    logic [DATA_W-1:0] dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              rd_ready;
    logic              rd_valid;
    logic [RD_W-1:0]   rd_data;

    // Trace source and drain consumer side
    modport master (
        output dct_valid, dct_buffer, dct_count, rd_ready,
        input  rd_valid, rd_data
    );

    // Capture block side
    modport slave (
        input  dct_valid, dct_buffer, dct_count, rd_ready,
        output rd_valid, rd_data
    );
endinterface

`default_nettype wire

// File: rtl/uart_cpu_oci_trace_capture.sv
//------------------------------------------------------------------------------
// Module      : uart_cpu_oci_trace_capture
// Description : OCI trace capture FIFO with end-of-test FSM, first-word
//               fall-through drain port and sticky overflow/drop statistics.
//               Optional feature macro: OCI_TRACE_TIMESTAMP_EN stores a
//               free-running TS_W timestamp with every entry.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_cpu_oci_trace_capture #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    uart_cpu_oci_trace_capture_if.slave   bus,
    input  wire logic                     test_ending,
    input  wire logic                     test_has_ended,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    output logic [1:0]                    state,
    output logic                          done
);
`ifdef OCI_TRACE_TIMESTAMP_EN
    localparam int TS_EN = 1;
`else
    localparam int TS_EN = 0;
`endif
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = CNT_W + DATA_W + (TS_EN * TS_W);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [ENTRY_W-1:0] w_entry;
    logic               w_push_req;
    logic               w_can_write;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_end;

`ifdef OCI_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]    r_ts;

    // Free-running timestamp, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) r_ts <= '0;
        else       r_ts <= r_ts + 1'b1;
    end

    assign w_entry = {r_ts, bus.dct_count, bus.dct_buffer};
`else
    assign w_entry = {bus.dct_count, bus.dct_buffer};
`endif

    // Zero-frame words are not real trace data and never count as drops
    assign w_push_req  = bus.dct_valid && (bus.dct_count != '0);
    // A push arriving in the same cycle as end-of-test is still honoured
    assign w_can_write = (r_state == ST_IDLE) || (r_state == ST_CAPTURE);
    assign w_full      = (level == C_FULL);
    assign w_pop       = bus.rd_valid && bus.rd_ready;
    // When full, a simultaneous pop frees the slot the push lands in
    assign w_push      = w_can_write && w_push_req && (!w_full || w_pop);
    assign w_drop      = w_can_write && w_push_req && w_full && !w_pop;
    assign w_end       = test_ending || test_has_ended;

    // Head entry falls through combinationally from the read pointer
    assign bus.rd_valid = (r_wr_ptr != r_rd_ptr);
    assign bus.rd_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign state        = r_state;

    // Storage array; contents are meaningless once pointers are reset
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
    end

    // Pointers, occupancy, statistics and end-of-test FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            done       <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (w_drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_end)           r_state <= ST_DRAIN;
                    else if (w_push_req) r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (w_end) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if ((level == '0) && !w_pop && test_has_ended) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_DONE;
                    done    <= 1'b1;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_uart_cpu_oci_trace_capture.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_cpu_oci_trace_capture
// Description : Directed self-checking bench for uart_cpu_oci_trace_capture.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_cpu_oci_trace_capture;
    localparam int DATA_W = 30;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int LOW_W  = CNT_W + DATA_W;

    logic        clk;
    logic        reset;
    logic        test_ending;
    logic        test_has_ended;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_count;
    logic [1:0]  state;
    logic        done;

    int tests = 0;
    int fails = 0;

    uart_cpu_oci_trace_capture_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TS_W(TS_W)) tif ();

    uart_cpu_oci_trace_capture #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .TS_W(TS_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (tif.slave),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .level          (level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .state          (state),
        .done           (done)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LOW_W-1:0] fill_word(input int i);
        logic [CNT_W-1:0]  c;
        logic [DATA_W-1:0] d;
        c = CNT_W'((i % 15) + 1);
        d = DATA_W'(32'h100 + i);
        return {c, d};
    endfunction

    logic [LOW_W-1:0] exp_w;
`ifdef OCI_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts0;
    logic [TS_W-1:0] ts1;
`endif

    // Directed stimulus and checks
    initial begin
        reset          = 1'b1;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        tif.dct_valid  = 1'b0;
        tif.dct_buffer = '0;
        tif.dct_count  = '0;
        tif.rd_ready   = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        chk("rst_state",    64'(state), 64'd0);
        chk("rst_level",    64'(level), 64'd0);
        chk("rst_rd_valid", 64'(tif.rd_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drops",    64'(drop_count), 64'd0);
        chk("rst_done",     64'(done), 64'd0);

        // Zero-frame word in IDLE is ignored
        tif.dct_valid = 1'b1; tif.dct_count = 4'h0; tif.dct_buffer = 30'h1234;
        step();
        chk("cnt0_idle_state", 64'(state), 64'd0);
        chk("cnt0_idle_level", 64'(level), 64'd0);
        chk("cnt0_idle_drops", 64'(drop_count), 64'd0);

        // First real word: IDLE -> CAPTURE, visible right after the edge
        tif.dct_buffer = 30'h2AAAAAAA; tif.dct_count = 4'h3;
        step();
        tif.dct_valid = 1'b0;
        chk("first_state",    64'(state), 64'd1);
        chk("first_rd_valid", 64'(tif.rd_valid), 64'd1);
        chk("first_rd_data",  64'(tif.rd_data[LOW_W-1:0]), 64'({4'h3, 30'h2AAAAAAA}));
        chk("first_level",    64'(level), 64'd1);

        // Zero-frame word in CAPTURE is ignored
        tif.dct_valid = 1'b1; tif.dct_count = 4'h0;
        step();
        tif.dct_valid = 1'b0;
        chk("cnt0_cap_state", 64'(state), 64'd1);
        chk("cnt0_cap_level", 64'(level), 64'd1);
        chk("cnt0_cap_drops", 64'(drop_count), 64'd0);

        // Pop the single entry
        tif.rd_ready = 1'b1;
        step();
        tif.rd_ready = 1'b0;
        chk("pop1_level",    64'(level), 64'd0);
        chk("pop1_rd_valid", 64'(tif.rd_valid), 64'd0);

        // Overfill: 20 pushes into 16 entries
        for (int i = 0; i < 20; i++) begin
            tif.dct_valid = 1'b1;
            {tif.dct_count, tif.dct_buffer} = fill_word(i);
            step();
        end
        tif.dct_valid = 1'b0;
        chk("ovf_level",    64'(level), 64'd16);
        chk("ovf_overflow", 64'(overflow), 64'd1);
        chk("ovf_drops",    64'(drop_count), 64'd4);
        chk("ovf_head",     64'(tif.rd_data[LOW_W-1:0]), 64'(fill_word(0)));

        // Push and pop together while full: accepted, no drop
        tif.dct_valid = 1'b1; tif.dct_buffer = 30'h3FFFFFFF; tif.dct_count = 4'hF;
        tif.rd_ready = 1'b1;
        step();
        tif.dct_valid = 1'b0;
        chk("fullpp_level", 64'(level), 64'd16);
        chk("fullpp_drops", 64'(drop_count), 64'd4);

        // Drain: words 1..15 in order, then the word written while full
        for (int i = 0; i < 16; i++) begin
            exp_w = (i < 15) ? fill_word(i + 1) : {4'hF, 30'h3FFFFFFF};
            chk($sformatf("drain1_%0d", i), 64'(tif.rd_data[LOW_W-1:0]), 64'(exp_w));
            step();
        end
        tif.rd_ready = 1'b0;
        chk("drain1_level", 64'(level), 64'd0);

        // Five entries; the fifth arrives in the test_ending cycle
        for (int i = 0; i < 5; i++) begin
            tif.dct_valid = 1'b1;
            tif.dct_buffer = DATA_W'(32'h2000 + i); tif.dct_count = 4'h2;
            test_ending = (i == 4);
            step();
        end
        chk("end_state", 64'(state), 64'd2);
        chk("end_level", 64'(level), 64'd5);

        // Pushes in DRAIN are ignored and not counted
        for (int i = 0; i < 3; i++) begin
            tif.dct_buffer = DATA_W'(32'h3000 + i);
            step();
        end
        tif.dct_valid = 1'b0;
        chk("drainpush_level", 64'(level), 64'd5);
        chk("drainpush_drops", 64'(drop_count), 64'd4);

        // Drain the five words with test_has_ended
        test_has_ended = 1'b1;
        tif.rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain2_%0d", i), 64'(tif.rd_data[LOW_W-1:0]),
                64'({4'h2, DATA_W'(32'h2000 + i)}));
            step();
        end
        tif.rd_ready = 1'b0;
        chk("drain2_level", 64'(level), 64'd0);
        chk("drain2_state", 64'(state), 64'd2);
        chk("drain2_done0", 64'(done), 64'd0);
        step();
        chk("done_state", 64'(state), 64'd3);
        chk("done_flag",  64'(done), 64'd1);

        // DONE ignores pushes
        tif.dct_valid = 1'b1; tif.dct_count = 4'h1;
        step();
        tif.dct_valid = 1'b0;
        chk("done_push_state", 64'(state), 64'd3);
        chk("done_push_level", 64'(level), 64'd0);

        // Fresh run, overflow, then reset in the middle of the drain
        reset = 1'b1; test_ending = 1'b0; test_has_ended = 1'b0;
        step();
        reset = 1'b0;
        chk("rst2_state", 64'(state), 64'd0);
        chk("rst2_done",  64'(done), 64'd0);
        for (int i = 0; i < 18; i++) begin
            tif.dct_valid = 1'b1;
            tif.dct_buffer = DATA_W'(32'h4000 + i); tif.dct_count = 4'h1;
            step();
        end
        tif.dct_valid = 1'b0;
        chk("run2_overflow", 64'(overflow), 64'd1);
        chk("run2_drops",    64'(drop_count), 64'd2);
        test_ending = 1'b1;
        step();
        chk("run2_state", 64'(state), 64'd2);
        tif.rd_ready = 1'b1;
        repeat (9) step();
        tif.rd_ready = 1'b0;
        chk("run2_level7", 64'(level), 64'd7);
        reset = 1'b1;
        step();
        reset = 1'b0; test_ending = 1'b0;
        chk("midrst_level",    64'(level), 64'd0);
        chk("midrst_rd_valid", 64'(tif.rd_valid), 64'd0);
        chk("midrst_state",    64'(state), 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        chk("midrst_drops",    64'(drop_count), 64'd0);

`ifdef OCI_TRACE_TIMESTAMP_EN
        // Back-to-back pushes carry consecutive timestamps
        for (int i = 0; i < 2; i++) begin
            tif.dct_valid = 1'b1;
            tif.dct_buffer = DATA_W'(32'h5000 + i); tif.dct_count = 4'h1;
            step();
        end
        tif.dct_valid = 1'b0;
        ts0 = tif.rd_data[LOW_W +: TS_W];
        tif.rd_ready = 1'b1;
        step();
        tif.rd_ready = 1'b0;
        ts1 = tif.rd_data[LOW_W +: TS_W];
        chk("ts_delta", 64'(ts1), 64'(TS_W'(ts0 + 1'b1)));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
